// File: rtl/phy_lane_sync_ctrl_pkg.sv
// Shared definitions for the two-lane PHY symbol-lock / link bring-up controller.
package pkg_phy_defs;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;
    localparam int         NUM_LANES  = 2;
    localparam int         CNT_W      = 4;

    typedef enum logic [1:0] {
        LINK_RESET  = 2'd0,
        LINK_TRAIN  = 2'd1,
        LINK_ACTIVE = 2'd2
    } link_state_t;

    typedef enum logic {
        LANE_LOS    = 1'b0,
        LANE_LOCKED = 1'b1
    } lane_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } lane_byte_t;

endpackage

// File: rtl/lane_sync_fsm.sv
// Per-lane symbol lock: SYNC_COUNT back-to-back COMs acquire lock, LOS_LIMIT idle cycles lose it.
module lane_sync_fsm #(
    parameter logic [7:0]  COM_SYMBOL = pkg_phy_defs::COM_SYMBOL,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned LOS_LIMIT  = 4
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic       clear,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       locked
);
    import pkg_phy_defs::*;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COUNT - 1);
    localparam logic [CNT_W-1:0] LOS_LAST  = CNT_W'(LOS_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    lane_state_t      state_q, state_d;
    logic [CNT_W-1:0] com_cnt_q, com_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             is_com;

    assign is_com = valid_in && (data_in == COM_SYMBOL);
    assign locked = (state_q == LANE_LOCKED);

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (clear) begin
            state_d   = LANE_LOS;
            com_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                LANE_LOS: begin
                    gap_cnt_d = '0;
                    if (!is_com) begin
                        com_cnt_d = '0;
                    end else if (com_cnt_q == SYNC_LAST) begin
                        state_d   = LANE_LOCKED;
                        com_cnt_d = '0;
                    end else if (com_cnt_q != CNT_MAX) begin
                        com_cnt_d = com_cnt_q + 1'b1;
                    end
                end
                LANE_LOCKED: begin
                    com_cnt_d = '0;
                    // any valid byte keeps the lane alive, COM or data
                    if (valid_in) begin
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q == LOS_LAST) begin
                        state_d   = LANE_LOS;
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q != CNT_MAX) begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = LANE_LOS;
                    com_cnt_d = '0;
                    gap_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= LANE_LOS;
            com_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: rtl/phy_lane_sync_ctrl.sv
// Two-lane link bring-up: lane lock detectors plus the RESET/TRAIN/ACTIVE link FSM.
module phy_lane_sync_ctrl #(
    parameter logic [7:0]  COM_SYMBOL = pkg_phy_defs::COM_SYMBOL,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned LOS_LIMIT  = 4
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic       valid_in_lane0,
    input  logic [7:0] data_in_lane0,
    input  logic       valid_in_lane1,
    input  logic [7:0] data_in_lane1,
    input  logic       retrain,
    output logic       active_lane0,
    output logic       active_lane1,
    output logic       link_up,
    output logic       send_com,
    output logic [1:0] link_state
);
    import pkg_phy_defs::*;

    lane_byte_t [NUM_LANES-1:0] lane_in;
    logic       [NUM_LANES-1:0] lane_locked;
    logic                       lane_clear;

    link_state_t link_state_q, link_state_d;
    logic        send_com_q, send_com_d;
    logic        link_up_q, link_up_d;

    assign lane_in[0].valid = valid_in_lane0;
    assign lane_in[0].data  = data_in_lane0;
    assign lane_in[1].valid = valid_in_lane1;
    assign lane_in[1].data  = data_in_lane1;

    // retrain is ignored during the single RESET cycle after reset release
    assign lane_clear = retrain && (link_state_q != LINK_RESET);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_sync_fsm #(
            .COM_SYMBOL (COM_SYMBOL),
            .SYNC_COUNT (SYNC_COUNT),
            .LOS_LIMIT  (LOS_LIMIT)
        ) u_lane (
            .clk_4f   (clk_4f),
            .reset_L  (reset_L),
            .clear    (lane_clear),
            .valid_in (lane_in[g].valid),
            .data_in  (lane_in[g].data),
            .locked   (lane_locked[g])
        );
    end

    always_comb begin
        link_state_d = link_state_q;
        case (link_state_q)
            LINK_RESET:  link_state_d = LINK_TRAIN;
            LINK_TRAIN:  if (!retrain && (&lane_locked)) link_state_d = LINK_ACTIVE;
            LINK_ACTIVE: if (retrain || !(&lane_locked)) link_state_d = LINK_TRAIN;
            default:     link_state_d = LINK_RESET;
        endcase
        send_com_d = (link_state_d == LINK_TRAIN);
        link_up_d  = (link_state_d == LINK_ACTIVE);
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            link_state_q <= LINK_RESET;
            send_com_q   <= 1'b0;
            link_up_q    <= 1'b0;
        end else begin
            link_state_q <= link_state_d;
            send_com_q   <= send_com_d;
            link_up_q    <= link_up_d;
        end
    end

    assign active_lane0 = lane_locked[0];
    assign active_lane1 = lane_locked[1];
    assign link_up      = link_up_q;
    assign send_com     = send_com_q;
    assign link_state   = link_state_q;

endmodule

// File: doc/phy_lane_sync_ctrl.md
Name: phy_lane_sync_ctrl

Overview:
- Per-lane symbol-lock and link-bring-up controller for the two-lane PHY.
- Watches the byte stream of each lane at byte rate and declares a lane synchronised after consecutive COM symbols. It drops sync after a run of invalid bytes.
- Drives active_lane0/active_lane1 into phy_tx, so recirculation gates traffic until both lanes are up. Asserts send_com while training, so the transmitter emits COM.

Parameters:
- COM_SYMBOL, 8'hBC, comma/alignment byte value.
- SYNC_COUNT, 4, consecutive valid COM bytes required for lock (range 1..15).
- LOS_LIMIT, 4, consecutive cycles with valid low that cause loss of sync while locked (range 1..15).

Ports:
- clk_4f  input  1  byte-rate clock; the only clock.
- reset_L  input  1  asynchronous, active-low reset.
- valid_in_lane0  input  1  byte valid, lane 0.
- data_in_lane0  input  8  byte, lane 0.
- valid_in_lane1  input  1  byte valid, lane 1.
- data_in_lane1  input  8  byte, lane 1.
- retrain  input  1  single-cycle request to drop the link and retrain.
- active_lane0  output  1  lane 0 locked.
- active_lane1  output  1  lane 1 locked.
- link_up  output  1  both lanes locked and link in ACTIVE.
- send_com  output  1  transmitter shall insert COM_SYMBOL.
- link_state  output  2  top FSM state encoding: RESET=0, TRAIN=1, ACTIVE=2.

Behaviour:
- All outputs are registered on the rising edge of clk_4f.
- While reset_L=0 (asynchronous):
  - active_lane0=0, active_lane1=0, link_up=0, send_com=0.
  - link_state=RESET.
  - Lane counters are 0 and both lane FSMs are in LOS.

Lane FSM (one instance per lane):
- States are LOS and LOCKED; each lane has a 4-bit com_cnt and a 4-bit gap_cnt.
- LOS:
  - valid & data==COM_SYMBOL: com_cnt++.
  - Any other byte, or valid=0: com_cnt=0.
  - When a qualifying COM arrives with com_cnt==SYNC_COUNT-1: go to LOCKED, clear com_cnt, and set active_laneX=1 on that same edge.
  - Latency is exactly 1 cycle after the SYNC_COUNT-th COM is sampled.
- LOCKED:
  - valid=1: gap_cnt=0 (any byte value is accepted, COM included).
  - valid=0: gap_cnt++.
  - When gap_cnt==LOS_LIMIT-1 and valid=0 again: go to LOS, clear gap_cnt, and set active_laneX=0 on that edge.
- A lane-level clear (from retrain) forces LOS, clears both counters and sets active_laneX=0. It has priority over all other transitions.
- Counters saturate and never wrap.

Top FSM:
- RESET: go to TRAIN on the first clock after reset release. send_com=0.
- TRAIN: send_com=1. When active_lane0 & active_lane1 are both registered high, go to ACTIVE; link_up=1 one cycle after the second lane locks.
- ACTIVE:
  - send_com=0, link_up=1.
  - If either lane drops lock, go to TRAIN with link_up=0 one cycle after the lane drop.
  - retrain=1 in any state except RESET: go to TRAIN, clear both lanes, and set link_up=0 and active_lane*=0 on that edge.
  - retrain takes priority over a simultaneous lock or unlock.

Boundary rules:
- A lane that locks and then unlocks during TRAIN before the other lane locks: the link stays in TRAIN.
- Both lanes locking on the same edge: ACTIVE on the next edge.
- retrain held high for several cycles: lanes are held in LOS for the whole time; training resumes on the first cycle after retrain falls.
- Reset asserted mid-operation returns every output to its reset value immediately.

Decomposition:
- Shared package pkg_phy_defs:
  - COM_SYMBOL constant.
  - link_state encodings RESET/TRAIN/ACTIVE.
  - Lane state encodings LOS/LOCKED.
- One sub-module, lane_sync_fsm, instantiated twice. It takes clk_4f, reset_L, clear, valid_in and data_in, and produces locked.
- The top holds the link FSM and the output registers.

Test Plan:
- Lock lane 0 only: reset, then 4 valid 8'hBC on lane 0 with lane 1 idle → active_lane0=1 on the edge after the 4th BC. active_lane1=0, link_state=TRAIN, send_com=1.
- Interrupted lock: lane 0 sends BC,BC,BC,8'h55,BC,BC,BC,BC → no lock after the first three. active_lane0 rises only after the final four BC.
- Both lanes lock: both lanes send 4 BC simultaneously → both active_lane* rise on the same edge. link_up=1 and link_state=ACTIVE one cycle later, send_com=0.
- Loss of sync: from ACTIVE, lane 1 valid=0 for 4 cycles → active_lane1=0 after the 4th. Then link_up=0, link_state=TRAIN, send_com=1 one cycle later. With only 3 idle cycles followed by a valid byte there is no drop.
- Retrain: from ACTIVE, pulse retrain for 1 cycle → on that edge active_lane0=active_lane1=0, link_up=0, link_state=TRAIN. Re-lock requires 4 fresh BC per lane.
- Async reset mid-lock: assert reset_L=0 after 2 BC on each lane → all outputs 0 immediately. After release, link_state=TRAIN and 4 new BC are needed to lock.
